// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - sync-hunting, length-prefixed, checksummed packet deframer behind a UART receiver
// Buffers one verified frame and replays it on a valid/ready stream; bad frames are dropped with an error pulse.
module uart_rx_deframer #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 100000
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Dv,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Data_Valid,
    output logic [7:0] o_Data,
    output logic       o_Data_Last,
    input  logic       i_Data_Ready,
    output logic       o_Frame_Ok,
    output logic       o_Frame_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Busy
);
    localparam int             IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int             GW        = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [GW-1:0]  GAP_MAX   = GW'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;

    state_t        r_state, w_next_state;
    logic [7:0]    r_len, r_wr_idx, r_rd_idx, r_sum;
    logic [GW-1:0] r_gap;
    logic [7:0]    r_buf [MAX_LEN];
    logic          r_frame_ok, r_frame_err;
    logic [1:0]    r_err_code;
    logic          w_in_frame, w_timeout, w_handshake, w_last_beat;
    logic          w_ok, w_err;
    logic [1:0]    w_code;

    assign w_in_frame  = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CSUM);
    // A byte arriving on the final gap cycle beats the timeout.
    assign w_timeout   = w_in_frame && !i_Rx_Dv && (r_gap == GAP_MAX);
    assign w_handshake = (r_state == S_DRAIN) && i_Data_Ready;
    assign w_last_beat = (r_rd_idx == r_len - 8'd1);

    always_comb begin
        w_next_state = r_state;
        w_ok         = 1'b0;
        w_err        = 1'b0;
        w_code       = r_err_code;
        case (r_state)
            S_HUNT: begin
                if (i_Rx_Dv && (i_Rx_Byte == SYNC_BYTE))
                    w_next_state = S_LEN;
            end
            S_LEN: begin
                if (i_Rx_Dv) begin
                    if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > MAX_LEN_B)) begin
                        w_err        = 1'b1;
                        w_code       = 2'd1;
                        w_next_state = S_HUNT;
                    end else begin
                        w_next_state = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_Rx_Dv && (r_wr_idx == r_len - 8'd1))
                    w_next_state = S_CSUM;
            end
            S_CSUM: begin
                if (i_Rx_Dv) begin
                    if (i_Rx_Byte == r_sum) begin
                        w_ok         = 1'b1;
                        w_next_state = S_DRAIN;
                    end else begin
                        w_err        = 1'b1;
                        w_code       = 2'd2;
                        w_next_state = S_HUNT;
                    end
                end
            end
            S_DRAIN: begin
                if (i_Rx_Dv) begin
                    w_err  = 1'b1;
                    w_code = 2'd0;
                end
                if (w_handshake && w_last_beat)
                    w_next_state = S_HUNT;
            end
            default: w_next_state = S_HUNT;
        endcase
        if (w_timeout) begin
            w_err        = 1'b1;
            w_code       = 2'd3;
            w_next_state = S_HUNT;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state     <= S_HUNT;
            r_len       <= 8'd0;
            r_wr_idx    <= 8'd0;
            r_rd_idx    <= 8'd0;
            r_sum       <= 8'd0;
            r_gap       <= '0;
            r_frame_ok  <= 1'b0;
            r_frame_err <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_state     <= w_next_state;
            r_frame_ok  <= w_ok;
            r_frame_err <= w_err;
            if (w_err)
                r_err_code <= w_code;
            r_gap <= (i_Rx_Dv || !w_in_frame) ? '0 : r_gap + GW'(1);
            if ((r_state == S_LEN) && (w_next_state == S_PAYLOAD)) begin
                r_len    <= i_Rx_Byte;
                r_sum    <= i_Rx_Byte;
                r_wr_idx <= 8'd0;
            end
            if ((r_state == S_PAYLOAD) && i_Rx_Dv) begin
                r_wr_idx <= r_wr_idx + 8'd1;
                r_sum    <= r_sum + i_Rx_Byte;
            end
            if (w_ok)
                r_rd_idx <= 8'd0;
            else if (w_handshake)
                r_rd_idx <= r_rd_idx + 8'd1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if ((r_state == S_PAYLOAD) && i_Rx_Dv)
            r_buf[r_wr_idx[IW-1:0]] <= i_Rx_Byte;
    end

    assign o_Data_Valid = (r_state == S_DRAIN);
    assign o_Data       = o_Data_Valid ? r_buf[r_rd_idx[IW-1:0]] : 8'd0;
    assign o_Data_Last  = o_Data_Valid && w_last_beat;
    assign o_Frame_Ok   = r_frame_ok;
    assign o_Frame_Err  = r_frame_err;
    assign o_Err_Code   = r_err_code;
    assign o_Busy       = (r_state != S_HUNT);
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - directed self-checking bench for uart_rx_deframer
module tb_uart_rx_deframer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic       rdy = 1'b1;
    logic       o_dv, o_last, o_ok, o_err, o_busy;
    logic [7:0] o_data;
    logic [1:0] o_code;

    int n_checks = 0;
    int n_fail = 0;
    int ready_mode = 0;
    int exp_oks = 0;
    logic [8:0] exp_beats[$];
    int exp_errs[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       prev_last = 1'b0;
    logic [8:0] cmp_e;
    logic [7:0] q[$];

    always #5 clk = ~clk;

    uart_rx_deframer #(.SYNC_BYTE(8'hA5), .MAX_LEN(16), .TIMEOUT_CLKS(50)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Dv(dv), .i_Rx_Byte(rx_byte),
        .o_Data_Valid(o_dv), .o_Data(o_data), .o_Data_Last(o_last), .i_Data_Ready(rdy),
        .o_Frame_Ok(o_ok), .o_Frame_Err(o_err), .o_Err_Code(o_code), .o_Busy(o_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] csum(input logic [7:0] p[$]);
        int s = p.size();
        foreach (p[i]) s += int'(p[i]);
        return 8'(s);
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        dv = 1'b1;
        rx_byte = b;
        @(posedge clk); #1;
        dv = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] p[$]);
        foreach (p[i]) exp_beats.push_back({(i == p.size() - 1), p[i]});
        exp_oks++;
    endtask

    task automatic send_good(input logic [7:0] p[$]);
        send_byte(8'hA5);
        send_byte(8'(p.size()));
        foreach (p[i]) send_byte(p[i]);
        expect_frame(p);
        send_byte(csum(p));
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (o_busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_idle"}, o_busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_beats_left"}, exp_beats.size(), 0);
        chk({name, "_errs_left"}, exp_errs.size(), 0);
        chk({name, "_oks_left"}, exp_oks, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'b0;
            endcase
        end
    end

    // Scoreboard: stream beats, ok pulses and error codes against the expectation queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", o_dv, 1);
                    chk("stall_data", o_data, prev_data);
                    chk("stall_last", o_last, prev_last);
                end
                if (o_dv && rdy) begin
                    chk("beat_expected", exp_beats.size() != 0, 1);
                    if (exp_beats.size() != 0) begin
                        cmp_e = exp_beats.pop_front();
                        chk("beat_data", o_data, cmp_e[7:0]);
                        chk("beat_last", o_last, cmp_e[8]);
                    end
                end
                prev_stall = o_dv && !rdy;
                prev_data  = o_data;
                prev_last  = o_last;
                if (o_ok) begin
                    chk("ok_expected", exp_oks > 0, 1);
                    if (exp_oks > 0) exp_oks--;
                end
                if (o_err) begin
                    chk("err_expected", exp_errs.size() != 0, 1);
                    if (exp_errs.size() != 0) chk("err_code", o_code, exp_errs.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", o_dv, 0);
        chk("rst_data", o_data, 0);
        chk("rst_last", o_last, 0);
        chk("rst_ok", o_ok, 0);
        chk("rst_err", o_err, 0);
        chk("rst_code", o_code, 0);
        chk("rst_busy", o_busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Good frame, latency and back-to-back sync after the last handshake
        q = {8'h11, 8'h22, 8'h33};
        chk("csum_literal", csum(q), 8'h69);
        send_byte(8'hA5);
        send_byte(8'h03);
        foreach (q[i]) send_byte(q[i]);
        expect_frame(q);
        send_byte(8'h69);
        @(negedge clk);
        chk("good_ok", o_ok, 1);
        chk("good_v0", o_dv, 1);
        chk("good_d0", o_data, 8'h11);
        chk("good_l0", o_last, 0);
        @(negedge clk);
        chk("good_ok_width", o_ok, 0);
        chk("good_d1", o_data, 8'h22);
        @(negedge clk);
        chk("good_d2", o_data, 8'h33);
        chk("good_l2", o_last, 1);
        @(posedge clk); #1;
        dv = 1'b1;
        rx_byte = 8'hA5;
        @(negedge clk);
        chk("good_busy_after", o_busy, 0);
        chk("good_valid_after", o_dv, 0);
        @(posedge clk); #1;
        dv = 1'b0;
        @(negedge clk);
        chk("sync_accepted", o_busy, 1);
        exp_beats.push_back({1'b1, 8'h5A});
        exp_oks++;
        send_byte(8'h01);
        send_byte(8'h5A);
        send_byte(8'h5B);
        wait_idle("good");

        // Bad checksum then a 1-byte good frame
        exp_errs.push_back(2);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h31);
        @(negedge clk);
        chk("badcs_code", o_code, 2);
        q = {8'h7E};
        chk("csum_1byte_literal", csum(q), 8'h7F);
        send_good(q);
        wait_idle("badcs");

        // Bad lengths with garbage in between
        exp_errs.push_back(1);
        send_byte(8'hA5); send_byte(8'h00);
        send_byte(8'h33); send_byte(8'h44);
        exp_errs.push_back(1);
        send_byte(8'hA5); send_byte(8'h11);
        send_byte(8'h11); send_byte(8'h22);
        @(negedge clk);
        chk("badlen_busy", o_busy, 0);
        chk("badlen_code", o_code, 1);
        wait_idle("badlen");

        // Timeout exactly 50 clocks after the last byte
        exp_errs.push_back(3);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        repeat (49) @(posedge clk);
        @(negedge clk);
        chk("to_not_early", o_err, 0);
        @(posedge clk);
        @(negedge clk);
        chk("to_pulse", o_err, 1);
        chk("to_code", o_code, 3);
        chk("to_busy", o_busy, 0);
        wait_idle("timeout");

        // Byte on the final gap cycle wins over the timeout
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        repeat (48) @(posedge clk);
        q = {8'h11, 8'h22};
        expect_frame(q);
        send_byte(8'h22);
        @(negedge clk);
        chk("no_to_busy", o_busy, 1);
        send_byte(8'h35);
        wait_idle("no_timeout");

        // Random backpressure
        ready_mode = 1;
        q = {8'hC3, 8'hA5, 8'h5A, 8'hFF};
        chk("csum_bp_literal", csum(q), 8'hC5);
        send_good(q);
        wait_idle("backpressure");
        ready_mode = 0;

        // Overrun while stalled
        ready_mode = 2;
        send_good({8'hAA, 8'hBB, 8'hCC});
        exp_errs.push_back(0);
        send_byte(8'h55);
        @(negedge clk);
        chk("ovr_code", o_code, 0);
        chk("ovr_valid", o_dv, 1);
        chk("ovr_data", o_data, 8'hAA);
        ready_mode = 0;
        wait_idle("overrun");

        // Reset mid-payload
        exp_errs.push_back(2);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", o_dv, 0);
        chk("mid_rst_data", o_data, 0);
        chk("mid_rst_last", o_last, 0);
        chk("mid_rst_ok", o_ok, 0);
        chk("mid_rst_err", o_err, 0);
        chk("mid_rst_code", o_code, 0);
        chk("mid_rst_busy", o_busy, 0);
        repeat (5) @(posedge clk);
        send_good({8'hDE, 8'hAD});
        wait_idle("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
